// File: rtl/data_mem_responder.sv
// Word-addressed data memory for the CPU datapath: request/ready handshake,
// fixed wait states, and an error response for misaligned or out-of-range addresses.
//
// state | meaning
// IDLE  | waiting for mem_req_i; request fields latched on acceptance
// WAIT  | counting down the fixed wait states
// RESP  | ready_o strobe; rdata_o / addr_err_o valid
module data_mem_responder #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        addr_err_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         addr_q, wdata_q;
    logic                we_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic [31:0]         mem_q [2**ADDR_W];

    logic                accept, enter_resp;
    logic                acc_we, acc_err;
    logic [31:0]         acc_addr, acc_wdata;
    logic [ADDR_W-1:0]   acc_idx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    accept = 1'b1;
                    if (WAIT_CYC > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the access completes on the accepting edge, so use live inputs in IDLE.
    assign acc_addr  = (state_q == IDLE) ? addr_i  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? wdata_i : wdata_q;
    assign acc_we    = (state_q == IDLE) ? mem_we_i : we_q;
    assign acc_idx   = acc_addr[ADDR_W+1:2];
    assign acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                we_q    <= mem_we_i;
            end
            if (enter_resp) begin
                err_q <= acc_err;
                if (acc_err) begin
                    rdata_q <= 32'd0;
                end else if (!acc_we) begin
                    rdata_q <= mem_q[acc_idx];
                end
            end
        end
    end

    // Array is never cleared; a reset before the commit edge drops the store.
    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_resp && acc_we && !acc_err) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign ready_o    = (state_q == RESP);
    assign addr_err_o = (state_q == RESP) && err_q;
    assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, hand-written corner sequences,
// and randomized accesses checked against an address-keyed memory model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we;
    logic [31:0] addr, wdata, rdata;
    logic        ready, addr_err;

    logic        req1, we1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        ready1, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(10), .WAIT_CYC(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .mem_req_i(mem_req), .mem_we_i(mem_we),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ready_o(ready),
        .addr_err_o(addr_err)
    );

    data_mem_responder #(.ADDR_W(4), .WAIT_CYC(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req1), .mem_we_i(we1),
        .addr_i(addr1), .wdata_i(wdata1), .rdata_o(rdata1), .ready_o(ready1),
        .addr_err_o(err1)
    );

    // Reference model: words written so far, keyed by word index, plus last response data.
    logic [31:0] mem_m [int];
    logic [31:0] rdata_m;
    bit          rdata_known;

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a, input int aw);
        return (a % 4 != 0) || (a >= (32'd4 << aw));
    endfunction

    function automatic void model_apply(input bit we, input logic [31:0] a, input logic [31:0] wd);
        int idx = int'(a / 4);
        if (model_err(a, 10)) begin
            rdata_m = 32'd0;
            rdata_known = 1'b1;
        end else if (we) begin
            mem_m[idx] = wd;
        end else if (mem_m.exists(idx)) begin
            rdata_m = mem_m[idx];
            rdata_known = 1'b1;
        end else begin
            rdata_known = 1'b0;
        end
    endfunction

    // Issues one request on the WAIT_CYC=2 instance; lat counts cycles after acceptance (0 = timeout).
    task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output bit err, output int lat);
        @(negedge clk);
        chk("ready_idle", {31'd0, ready}, 32'd0);
        mem_req = 1'b1; mem_we = we; addr = a; wdata = wd;
        @(negedge clk);
        mem_req = 1'b0;
        mem_we  = 1'($urandom_range(0, 1));
        addr    = $urandom;
        wdata   = $urandom;
        lat = 0; rd = 32'd0; err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (ready) begin
                lat = k; rd = rdata; err = addr_err;
                break;
            end
            chk("err_outside_resp", {31'd0, addr_err}, 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic acc0(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit err, output int lat);
        @(negedge clk);
        req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
        lat = 0; rd = 32'd0; err = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            req1 = 1'b0; addr1 = $urandom;
            if (ready1) begin
                lat = k; rd = rdata1; err = err1;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd, a, wd;
        bit          e, we;
        int          lat, cnt, sel;
        int          rc [$];

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0012, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 32'hA5A5_A5A5, 1'b0};
        vecs[8]  = '{1'b0, 32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0FFF, 32'h0,         32'h0000_0000, 1'b1};

        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; addr = '0; wdata = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        rdata_m = 32'd0; rdata_known = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_err", {31'd0, addr_err}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_rdata0", rdata1, 32'd0);

        foreach (vecs[i]) begin
            do_access(vecs[i].we, vecs[i].a, vecs[i].wd, rd, e, lat);
            model_apply(vecs[i].we, vecs[i].a, vecs[i].wd);
            chk($sformatf("vec%0d_lat", i), lat, 32'd3);
            chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // rdata must hold after the response
        do_access(1'b0, 32'h10, 32'h0, rd, e, lat);
        model_apply(1'b0, 32'h10, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rdata_hold", rdata, 32'hDEAD_BEEF);
        end

        // back-to-back with mem_req held high
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; addr = 32'h10;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (ready) begin
                rc.push_back(k);
                if (rc.size() == 1) begin
                    chk("b2b_first_rdata", rdata, 32'hDEAD_BEEF);
                    addr = 32'h14;
                end else begin
                    chk("b2b_second_rdata", rdata, 32'hCAFE_F00D);
                    mem_req = 1'b0;
                    break;
                end
            end
        end
        mem_req = 1'b0;
        model_apply(1'b0, 32'h14, 32'h0);
        chk("b2b_pulses", rc.size(), 32'd2);
        if (rc.size() == 2) begin
            chk("b2b_first_cycle", rc[0], 32'd3);
            chk("b2b_spacing", rc[1] - rc[0], 32'd4);
        end

        // reset during WAIT drops the store
        do_access(1'b1, 32'h20, 32'h55AA_55AA, rd, e, lat);
        model_apply(1'b1, 32'h20, 32'h55AA_55AA);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; addr = 32'h20; wdata = 32'h1111_1111;
        @(negedge clk);
        mem_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rdata", rdata, 32'd0);
        rdata_m = 32'd0; rdata_known = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (ready) cnt++;
            @(negedge clk);
        end
        chk("midrst_no_ready", cnt, 32'd0);

        // reset and request together: request not accepted
        rst = 1'b1; mem_req = 1'b1; mem_we = 1'b1; addr = 32'h20; wdata = 32'h2222_2222;
        @(negedge clk);
        rst = 1'b0; mem_req = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (ready) cnt++;
            @(negedge clk);
        end
        chk("rst_req_no_ready", cnt, 32'd0);
        do_access(1'b0, 32'h20, 32'h0, rd, e, lat);
        model_apply(1'b0, 32'h20, 32'h0);
        chk("midrst_load_rdata", rd, 32'h55AA_55AA);
        chk("midrst_load_err", {31'd0, e}, 32'd0);

        // zero-wait-state instance
        acc0(1'b1, 32'h8, 32'h1234_5678, rd, e, lat);
        chk("w0_store_lat", lat, 32'd1);
        chk("w0_store_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        chk("w0_ready_single", {31'd0, ready1}, 32'd0);
        acc0(1'b0, 32'h8, 32'h0, rd, e, lat);
        chk("w0_load_lat", lat, 32'd1);
        chk("w0_load_rdata", rd, 32'h1234_5678);
        acc0(1'b0, 32'h40, 32'h0, rd, e, lat);
        chk("w0_oor_err", {31'd0, e}, 32'd1);
        chk("w0_oor_rdata", rd, 32'd0);

        // randomized accesses against the model
        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 9));
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if (sel < 7) begin
                a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) * 4
                                                : 32'($urandom_range(1016, 1023)) * 4;
            end else if (sel < 9) begin
                a = 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(1, 3));
            end else begin
                a = 32'h1000 + ($urandom & 32'h7FFF_FFFC);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_access(we, a, wd, rd, e, lat);
            model_apply(we, a, wd);
            chk("rnd_lat", lat, 32'd3);
            chk("rnd_err", {31'd0, e}, {31'd0, model_err(a, 10)});
            if (rdata_known) chk("rnd_rdata", rd, rdata_m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
